// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - registered, handshaked addressing-mode-1 shifter (operand B and carry-out)
module shifter_pipe #(
  parameter int DATA_W = 32,
  parameter int SA_W   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       IR,
  input  logic [DATA_W-1:0] RM,
  input  logic [7:0]        RS,
  input  logic              CIN,
  input  logic              ENABLE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] SHIFTER_OPERAND,
  output logic              COUT
);

  typedef enum logic [1:0] {IDLE, RSH, HOLD} state_t;

  localparam logic [1:0]  LSL = 2'b00;
  localparam logic [1:0]  LSR = 2'b01;
  localparam logic [1:0]  ASR = 2'b10;
  localparam logic [1:0]  ROR = 2'b11;
  localparam logic [8:0]  DW_AMT  = 9'(DATA_W);
  localparam logic [SA_W:0] DW_IDX  = (SA_W+1)'(DATA_W);
  localparam logic [SA_W:0] ONE_IDX = (SA_W+1)'(1);

  state_t state, state_next;

  logic [DATA_W-1:0] rm_q;
  logic [7:0]        rs_q;
  logic [1:0]        type_q;
  logic              cin_q;
  logic [DATA_W-1:0] res_q;
  logic              cout_q;

  logic live_reg, xfer;

  logic [DATA_W-1:0] e_rm, e_res, rot;
  logic              e_cin, e_cout, e_rrx;
  logic [1:0]        e_type;
  logic [8:0]        e_amt;
  logic [SA_W-1:0]   r;
  logic [SA_W:0]     idx_l, idx_r;
  logic              carry_l, carry_r;

  logic [DATA_W-1:0] imm_val, imm_rot, res_d;
  logic [SA_W-1:0]   imm_r;
  logic              cout_d;

  logic unused_ir;
  assign unused_ir = ^{IR[31:28], IR[24:12]};

  function automatic logic [DATA_W-1:0] ror_f(input logic [DATA_W-1:0] x,
                                              input logic [SA_W-1:0]   amt);
    return (x >> amt) | (x << (DATA_W - int'(amt)));
  endfunction

  assign live_reg = ENABLE && (IR[27:25] == 3'b000) && IR[4];
  assign xfer     = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = live_reg ? RSH : HOLD;
      RSH:     state_next = HOLD;
      HOLD: begin
        if (OUT_READY) begin
          if (IN_VALID) state_next = live_reg ? RSH : HOLD;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state == IDLE) || ((state == HOLD) && OUT_READY);
    OUT_VALID = (state == HOLD);
  end

  // Shift engine operands: latched values in RSH, live inputs otherwise
  always_comb begin
    if (state == RSH) begin
      e_rm   = rm_q;
      e_cin  = cin_q;
      e_type = type_q;
      e_amt  = {1'b0, rs_q};
      e_rrx  = 1'b0;
    end else begin
      e_rm   = RM;
      e_cin  = CIN;
      e_type = IR[6:5];
      e_rrx  = 1'b0;
      if (IR[4]) begin
        e_amt = {1'b0, RS};
      end else if (IR[11:7] == 5'd0 && (IR[6:5] == LSR || IR[6:5] == ASR)) begin
        e_amt = DW_AMT;
      end else begin
        e_amt = {4'd0, IR[11:7]};
        e_rrx = (IR[6:5] == ROR) && (IR[11:7] == 5'd0);
      end
    end
  end

  // Carry indices wrap to an MSB-set value when out of range; that bit gates them to 0
  always_comb begin
    r       = e_amt[SA_W-1:0];
    idx_l   = DW_IDX - {1'b0, r};
    idx_r   = {1'b0, r} - ONE_IDX;
    carry_l = idx_l[SA_W] ? 1'b0 : e_rm[idx_l[SA_W-1:0]];
    carry_r = idx_r[SA_W] ? 1'b0 : e_rm[idx_r[SA_W-1:0]];
    rot     = ror_f(e_rm, r);
    e_res   = e_rm;
    e_cout  = e_cin;
    if (e_rrx) begin
      e_res  = {e_cin, e_rm[DATA_W-1:1]};
      e_cout = e_rm[0];
    end else if (e_amt != 9'd0) begin
      case (e_type)
        LSL: begin
          if (e_amt < DW_AMT) begin
            e_res = e_rm << e_amt; e_cout = carry_l;
          end else begin
            e_res = '0; e_cout = (e_amt == DW_AMT) ? e_rm[0] : 1'b0;
          end
        end
        LSR: begin
          if (e_amt < DW_AMT) begin
            e_res = e_rm >> e_amt; e_cout = carry_r;
          end else begin
            e_res = '0; e_cout = (e_amt == DW_AMT) ? e_rm[DATA_W-1] : 1'b0;
          end
        end
        ASR: begin
          if (e_amt < DW_AMT) begin
            e_res = DATA_W'($signed(e_rm) >>> e_amt); e_cout = carry_r;
          end else begin
            e_res = {DATA_W{e_rm[DATA_W-1]}}; e_cout = e_rm[DATA_W-1];
          end
        end
        default: begin
          e_res = rot; e_cout = rot[DATA_W-1];
        end
      endcase
    end
  end

  always_comb begin
    imm_val = {{(DATA_W-8){1'b0}}, IR[7:0]};
    imm_r   = SA_W'({IR[11:8], 1'b0});
    imm_rot = ror_f(imm_val, imm_r);
    if (state == RSH) begin
      res_d = e_res;  cout_d = e_cout;
    end else if (!ENABLE) begin
      res_d = RM;     cout_d = CIN;
    end else if (IR[27:25] == 3'b001) begin
      res_d  = imm_rot;
      cout_d = (IR[11:8] != 4'd0) ? imm_rot[DATA_W-1] : CIN;
    end else begin
      res_d = e_res;  cout_d = e_cout;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      rm_q   <= '0;
      rs_q   <= '0;
      type_q <= '0;
      cin_q  <= 1'b0;
    end else begin
      if (xfer && live_reg) begin
        rm_q   <= RM;
        rs_q   <= RS;
        type_q <= IR[6:5];
        cin_q  <= CIN;
      end
      if ((state == RSH) || (xfer && !live_reg)) begin
        res_q  <= res_d;
        cout_q <= cout_d;
      end
    end
  end

  assign SHIFTER_OPERAND = res_q;
  assign COUT            = cout_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - directed-vector bench for shifter_pipe
module tb_shifter_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IR = '0;
  logic [31:0] RM = '0;
  logic [7:0]  RS = '0;
  logic        CIN = 1'b0;
  logic        ENABLE = 1'b1;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] SHIFTER_OPERAND;
  logic        COUT;

  int vectors = 0;
  int miscompares = 0;

  shifter_pipe #(.DATA_W(32), .SA_W(5)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IR(IR), .RM(RM), .RS(RS), .CIN(CIN), .ENABLE(ENABLE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SHIFTER_OPERAND(SHIFTER_OPERAND), .COUT(COUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; OUT_READY held low until the result is checked
  task automatic run(input string tag, input logic [31:0] ir, input logic [31:0] rm,
                     input logic [7:0] rs, input logic cin, input logic en,
                     input logic [31:0] exp_op, input logic exp_c, input int exp_lat);
    int lat;
    IR = ir; RM = rm; RS = rs; CIN = cin; ENABLE = en;
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    check({tag, ".in_ready"}, 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IR = 32'hFFFF_FFFF; RM = 32'h5A5A_5A5A; RS = 8'hFF; CIN = ~cin;
    @(negedge CLK);
    lat = 1;
    while (!OUT_VALID && lat < 5) begin
      if (exp_lat == 2) check({tag, ".rsh_in_ready"}, 64'(IN_READY), 64'd0);
      @(negedge CLK);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".operand"}, 64'(SHIFTER_OPERAND), 64'(exp_op));
    check({tag, ".cout"}, 64'(COUT), 64'(exp_c));
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("reset.out_valid", 64'(OUT_VALID), 64'd0);
    check("reset.operand", 64'(SHIFTER_OPERAND), 64'd0);
    check("reset.cout", 64'(COUT), 64'd0);
    check("reset.in_ready", 64'(IN_READY), 64'd1);
    RST = 1'b0;
    @(negedge CLK);

    run("imm_rot2", 32'h0200_01FF, 32'h0, 8'h0, 1'b0, 1'b1, 32'hC000_003F, 1'b1, 1);
    run("imm_rot0", 32'h0200_00FF, 32'h0, 8'h0, 1'b0, 1'b1, 32'h0000_00FF, 1'b0, 1);
    run("lsl_imm0", 32'h0000_0000, 32'h8000_0001, 8'h0, 1'b0, 1'b1, 32'h8000_0001, 1'b0, 1);
    run("lsr_imm0", 32'h0000_0020, 32'h8000_0001, 8'h0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1);
    run("asr_imm0", 32'h0000_0040, 32'h8000_0001, 8'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1);
    run("rrx", 32'h0000_0060, 32'h0000_0003, 8'h0, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 1);
    run("lsl_imm4", 32'h0000_0200, 32'hF000_0001, 8'h0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1);
    run("lsr_imm1", 32'h0000_00A0, 32'h8000_0001, 8'h0, 1'b0, 1'b1, 32'h4000_0000, 1'b1, 1);
    run("ror_imm4", 32'h0000_0260, 32'h0000_000F, 8'h0, 1'b0, 1'b1, 32'hF000_0000, 1'b1, 1);
    run("lsl_reg32", 32'h0000_0010, 32'h0000_0001, 8'd32, 1'b0, 1'b1, 32'h0, 1'b1, 2);
    run("lsl_reg40", 32'h0000_0010, 32'h0000_0001, 8'd40, 1'b1, 1'b1, 32'h0, 1'b0, 2);
    run("ror_reg33", 32'h0000_0070, 32'h0000_0003, 8'd33, 1'b0, 1'b1, 32'h8000_0001, 1'b1, 2);
    run("lsr_reg4", 32'h0000_0030, 32'h8000_0010, 8'd4, 1'b1, 1'b1, 32'h0800_0001, 1'b0, 2);
    run("asr_reg200", 32'h0000_0050, 32'h8000_0000, 8'd200, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 2);
    run("lsl_reg0", 32'h0000_0010, 32'h0000_1234, 8'd0, 1'b1, 1'b1, 32'h0000_1234, 1'b1, 2);
    run("ror_reg32", 32'h0000_0070, 32'h8000_0002, 8'd32, 1'b0, 1'b1, 32'h8000_0002, 1'b1, 2);
    run("bypass", 32'h0000_0010, 32'hDEAD_BEEF, 8'd8, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1);

    // Backpressure with a queued second request
    IR = 32'h0200_00FF; RM = 32'h0; RS = 8'h0; CIN = 1'b0; ENABLE = 1'b1;
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    IR = 32'h0000_00A0; RM = 32'h8000_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp.out_valid", 64'(OUT_VALID), 64'd1);
      check("bp.operand", 64'(SHIFTER_OPERAND), 64'h0000_00FF);
      check("bp.cout", 64'(COUT), 64'd0);
      check("bp.in_ready", 64'(IN_READY), 64'd0);
    end
    OUT_READY = 1'b1;
    #1;
    check("bp.release_in_ready", 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("b2b.out_valid", 64'(OUT_VALID), 64'd1);
    check("b2b.operand", 64'(SHIFTER_OPERAND), 64'h4000_0000);
    check("b2b.cout", 64'(COUT), 64'd1);
    @(negedge CLK);
    check("b2b.drained", 64'(OUT_VALID), 64'd0);
    OUT_READY = 1'b0;

    // Reset while a register shift is in RSH
    IR = 32'h0000_0010; RM = 32'h0000_0001; RS = 8'd4; CIN = 1'b0; ENABLE = 1'b1;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_rsh.in_ready_rsh", 64'(IN_READY), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_rsh.out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_rsh.operand", 64'(SHIFTER_OPERAND), 64'd0);
    check("rst_rsh.cout", 64'(COUT), 64'd0);
    check("rst_rsh.in_ready", 64'(IN_READY), 64'd1);
    OUT_READY = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("rst_rsh.no_ghost", 64'(OUT_VALID), 64'd0);
    end
    OUT_READY = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
